wb_stage: RTL and testbench

// - Final (write-back) stage of the 5-stage RISC-V pipeline: selects ALU result or load data.
// - Drives the register-file write port.
// - Holds a one-deep registered copy of the last write for WB->ID bypass.
// - Keeps a retired-write counter.
// - Result select and register-file write outputs are purely combinational (same-cycle).

---
 rtl/wb_stage.sv | 153 +++++++++++++++
 tb/tb_wb_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Write-back stage of the 5-stage RISC-V pipeline.
//   * Selects the ALU result or the load data (combinational, zero latency).
//   * Drives the register-file write port; writes to x0 are suppressed.
//   * Keeps a one-deep registered copy of the last real write for the
//     WB->ID bypass path.
//   * Counts retired register writes (wraps, no saturation).
//
// Optional feature macro: LOAD_EXT_EN
//   When defined, adds mem_funct3/byte_off and performs load byte/half
//   alignment and sign/zero extension on the load data path.
//
// Ports
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   alu_result      in   ALU result from MEM/WB
//   mem_data        in   load data from MEM/WB
//   mem_to_reg      in   1: select load data, 0: select ALU result
//   reg_write       in   instruction writes rd
//   rd_addr         in   destination register
//   mem_funct3      in   load size/sign code        (LOAD_EXT_EN only)
//   byte_off        in   load byte offset in word   (LOAD_EXT_EN only)
//   write_back_data out  selected result (combinational)
//   rf_we           out  register-file write enable (combinational)
//   rf_waddr        out  register-file write address (combinational)
//   rf_wdata        out  register-file write data (combinational)
//   fwd_valid       out  last cycle performed a real write (registered)
//   fwd_rd          out  rd of the last real write (registered)
//   fwd_data        out  data of the last real write (registered)
//   retire_cnt      out  number of cycles with rf_we=1 (registered)
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic [REG_AW-1:0] rd_addr,
`ifdef LOAD_EXT_EN
  input  logic [2:0]        mem_funct3,
  input  logic [1:0]        byte_off,
`endif
  output logic [XLEN-1:0]   write_back_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
  output logic [CNT_W-1:0]  retire_cnt
);

`ifdef LOAD_EXT_EN
  // Align the addressed byte/half to bit 0, then size and extend it.
  // Halfword loads address on a 2-byte boundary, so byte_off[0] is dropped.
  // Unknown codes behave like LW (the aligned full word).
  function automatic logic [XLEN-1:0] load_extend(
    input logic [XLEN-1:0] data,
    input logic [2:0]      funct3,
    input logic [1:0]      off
  );
    logic [XLEN-1:0] byte_sh;
    logic [XLEN-1:0] half_sh;
    byte_sh = data >> {off, 3'b000};
    half_sh = data >> {off[1], 4'b0000};
    case (funct3)
      3'b000:  load_extend = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  load_extend = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
      3'b010:  load_extend = byte_sh;
      3'b100:  load_extend = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
      3'b101:  load_extend = {{(XLEN-16){1'b0}}, half_sh[15:0]};
      default: load_extend = byte_sh;
    endcase
  endfunction
`endif

  logic [XLEN-1:0]   load_data_s;
  logic [XLEN-1:0]   wb_data_s;
  logic              we_s;

  logic              fwd_valid_q, fwd_valid_d;
  logic [REG_AW-1:0] fwd_rd_q,    fwd_rd_d;
  logic [XLEN-1:0]   fwd_data_q,  fwd_data_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  // Load data path: optional alignment/extension of the memory word.
  always_comb begin
    load_data_s = mem_data;
`ifdef LOAD_EXT_EN
    load_data_s = load_extend(mem_data, mem_funct3, byte_off);
`endif
  end

  // Result select and register-file write port; only mem_to_reg steers data,
  // so reg_write/rd_addr can never disturb write_back_data.
  always_comb begin
    if (mem_to_reg) begin
      wb_data_s = load_data_s;
    end else begin
      wb_data_s = alu_result;
    end
    we_s = reg_write && (rd_addr != {REG_AW{1'b0}});
  end

  assign write_back_data = wb_data_s;
  assign rf_we           = we_s;
  assign rf_waddr        = rd_addr;
  assign rf_wdata        = wb_data_s;

  // Next state of the bypass copy and the retire counter.
  always_comb begin
    fwd_valid_d = we_s;
    fwd_rd_d    = fwd_rd_q;
    fwd_data_d  = fwd_data_q;
    cnt_d       = cnt_q;
    if (we_s) begin
      fwd_rd_d   = rd_addr;
      fwd_data_d = wb_data_s;
      cnt_d      = cnt_q + CNT_W'(1);
    end else begin
      fwd_rd_d   = fwd_rd_q;
      fwd_data_d = fwd_data_q;
      cnt_d      = cnt_q;
    end
  end

  // State registers; reset clears the bypass copy and the counter at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= {REG_AW{1'b0}};
      fwd_data_q  <= {XLEN{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_rd_q    <= fwd_rd_d;
      fwd_data_q  <= fwd_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign fwd_valid  = fwd_valid_q;
  assign fwd_rd     = fwd_rd_q;
  assign fwd_data   = fwd_data_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 8;   // narrow counter so wrap-around is reachable

  logic              clk;
  logic              rst_n;
  logic [XLEN-1:0]   alu_result;
  logic [XLEN-1:0]   mem_data;
  logic              mem_to_reg;
  logic              reg_write;
  logic [REG_AW-1:0] rd_addr;
  logic [2:0]        mem_funct3;
  logic [1:0]        byte_off;
  logic [XLEN-1:0]   write_back_data;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_rd;
  logic [XLEN-1:0]   fwd_data;
  logic [CNT_W-1:0]  retire_cnt;

  wb_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_result      (alu_result),
    .mem_data        (mem_data),
    .mem_to_reg      (mem_to_reg),
    .reg_write       (reg_write),
    .rd_addr         (rd_addr),
`ifdef LOAD_EXT_EN
    .mem_funct3      (mem_funct3),
    .byte_off        (byte_off),
`endif
    .write_back_data (write_back_data),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .fwd_valid       (fwd_valid),
    .fwd_rd          (fwd_rd),
    .fwd_data        (fwd_data),
    .retire_cnt      (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wbd;
    logic        we;
    logic [4:0]  waddr;
    logic        fv;
    logic [4:0]  frd;
    logic [31:0] fdata;
    int unsigned cnt;
  } exp_t;

  exp_t sb[$];

  int n_total  = 0;
  int n_passed = 0;

  // Reference architectural state
  bit          m_fv;
  logic [4:0]  m_frd;
  logic [31:0] m_fdata;
  int unsigned m_writes;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_passed++;
  endtask

  // Expected write-back value computed from the load rules with arithmetic.
  function automatic logic [31:0] ref_wb(input logic [31:0] alu, input logic [31:0] mem,
                                         input logic m2r, input logic [2:0] f3,
                                         input logic [1:0] bo);
    longint unsigned w, b, h;
    if (!m2r) return alu;
`ifdef LOAD_EXT_EN
    w = longint'(mem) / (longint'(1) << (8 * bo));
    b = w % 256;
    h = (longint'(mem) / (longint'(1) << (16 * bo[1]))) % 65536;
    case (f3)
      3'd0: return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      3'd1: return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
      3'd4: return 32'(b);
      3'd5: return 32'(h);
      default: return 32'(w);
    endcase
`else
    return mem;
`endif
  endfunction

  // Drive one instruction, push what the monitor should see this cycle,
  // then advance the reference state across the following clock edge.
  task automatic drive_cycle(input logic [31:0] alu, input logic [31:0] mem, input logic m2r,
                             input logic rw, input logic [4:0] rd,
                             input logic [2:0] f3, input logic [1:0] bo);
    exp_t e;
    @(posedge clk);
    #1;
    alu_result = alu; mem_data = mem; mem_to_reg = m2r;
    reg_write = rw; rd_addr = rd; mem_funct3 = f3; byte_off = bo;
    e.wbd   = ref_wb(alu, mem, m2r, f3, bo);
    e.we    = rw && (rd != 5'd0);
    e.waddr = rd;
    e.fv    = m_fv;
    e.frd   = m_frd;
    e.fdata = m_fdata;
    e.cnt   = m_writes % (1 << CNT_W);
    sb.push_back(e);
    m_fv = e.we;
    if (e.we) begin
      m_frd = rd; m_fdata = e.wbd; m_writes++;
    end
  endtask

  task automatic model_reset();
    m_fv = 1'b0; m_frd = 5'd0; m_fdata = 32'd0; m_writes = 0;
  endtask

  // Monitor: compare every presented cycle against the scoreboard.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("write_back_data", {32'd0, write_back_data}, {32'd0, e.wbd});
      check("rf_we",           {63'd0, rf_we},           {63'd0, e.we});
      check("rf_waddr",        {59'd0, rf_waddr},        {59'd0, e.waddr});
      check("rf_wdata",        {32'd0, rf_wdata},        {32'd0, e.wbd});
      check("fwd_valid",       {63'd0, fwd_valid},       {63'd0, e.fv});
      check("fwd_rd",          {59'd0, fwd_rd},          {59'd0, e.frd});
      check("fwd_data",        {32'd0, fwd_data},        {32'd0, e.fdata});
      check("retire_cnt",      {56'd0, retire_cnt},      64'(e.cnt));
    end
  end

  initial begin
    logic        rw;
    logic [4:0]  rd;
    model_reset();
    rst_n = 1'b0;
    alu_result = 32'hAAAA_AAAA; mem_data = 32'h5555_5555; mem_to_reg = 1'b0;
    reg_write = 1'b0; rd_addr = 5'd0; mem_funct3 = 3'd2; byte_off = 2'd0;
    #10;
    check("reset_sel_alu", {32'd0, write_back_data}, 64'hAAAA_AAAA);
    check("reset_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check("reset_retire_cnt", {56'd0, retire_cnt}, 64'd0);
    alu_result = 32'h1234_5678; mem_data = 32'hDEAD_BEEF; mem_to_reg = 1'b1;
    #1;
    check("reset_sel_mem", {32'd0, write_back_data}, 64'hDEAD_BEEF);
    @(negedge clk);
    rst_n = 1'b1;

    // Write to x0 is discarded; then a real write to x5.
    drive_cycle(32'h0000_0099, 32'h0, 1'b0, 1'b1, 5'd0, 3'd2, 2'd0);
    drive_cycle(32'h0000_0042, 32'h0, 1'b0, 1'b1, 5'd5, 3'd2, 2'd0);
    drive_cycle(32'h0000_0007, 32'h0, 1'b0, 1'b0, 5'd9, 3'd2, 2'd0);

    // Asynchronous reset between edges.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    reg_write = 1'b0;
    model_reset();
    #1;
    check("async_rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check("async_rst_fwd_rd", {59'd0, fwd_rd}, 64'd0);
    check("async_rst_fwd_data", {32'd0, fwd_data}, 64'd0);
    check("async_rst_retire_cnt", {56'd0, retire_cnt}, 64'd0);
    #1;
    rst_n = 1'b1;

`ifdef LOAD_EXT_EN
    drive_cycle(32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd3, 3'b000, 2'd1);
    drive_cycle(32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd4, 3'b101, 2'd2);
    drive_cycle(32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd4, 3'b001, 2'd3);
    drive_cycle(32'h0, 32'h0080_7F00, 1'b1, 1'b1, 5'd4, 3'b100, 2'd2);
`endif

    // Randomized traffic, mostly real writes so the narrow counter wraps.
    for (int i = 0; i < 700; i++) begin
      rw = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      drive_cycle($urandom, $urandom, 1'($urandom), rw, rd,
                  3'($urandom), 2'($urandom));
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
